// File: rtl/pong_sprite_renderer.sv
// pong_sprite_renderer: VGA timing plus a two-stage paddle/ball rasteriser fed by frame-latched shadow registers.
// Optional RENDER_WALLS_EN macro draws top and bottom walls (8 rows each) in the foreground colour.
module pong_sprite_renderer #(
  parameter int CLK_DIV    = 4,
  parameter int PADDLE_W   = 8,
  parameter int PADDLE_H   = 64,
  parameter int BALL_SZ    = 8,
  parameter int PADDLE_L_X = 16,
  parameter int PADDLE_R_X = 616,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic [31:0] reg_paddle_l,
  input  logic [31:0] reg_paddle_r,
  input  logic [31:0] reg_ball,
  input  logic [31:0] reg_ctrl,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [10:0] PL_X0 = 11'(PADDLE_L_X);
  localparam logic [10:0] PL_X1 = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic [10:0] PR_X0 = 11'(PADDLE_R_X);
  localparam logic [10:0] PR_X1 = 11'(PADDLE_R_X + PADDLE_W);
  localparam logic [10:0] PAD_H = 11'(PADDLE_H);
  localparam logic [10:0] BALL  = 11'(BALL_SZ);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             load;

  logic [8:0] sh_pl;
  logic [8:0] sh_pr;
  logic [9:0] sh_bx;
  logic [8:0] sh_by;
  logic       sh_en;
  logic [3:0] sh_fg;
  logic [3:0] sh_bg;

  logic [10:0] x;
  logic [10:0] y;
  logic        visible;
  logic        hit;
  logic        hsync_n;
  logic        vsync_n;
  logic [3:0]  pix;

  logic s1_visible;
  logic s1_hit;
  logic s1_hsync;
  logic s1_vsync;

  logic unused_reg_bits;
  assign unused_reg_bits = &{1'b0, reg_paddle_l[31:9], reg_paddle_r[31:9], reg_ball[31:26],
                             reg_ball[15:9], reg_ctrl[31:16], reg_ctrl[7:1]};

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign load = tick && (h_cnt == 10'd0) && (v_cnt == 10'(V_ACTIVE));

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == 10'(H_TOTAL - 1)) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Shadows change only on the first blank line so a CPU write never tears a visible frame.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      sh_pl       <= '0;
      sh_pr       <= '0;
      sh_bx       <= '0;
      sh_by       <= '0;
      sh_en       <= 1'b0;
      sh_fg       <= '0;
      sh_bg       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      if (load) begin
        sh_pl <= reg_paddle_l[8:0];
        sh_pr <= reg_paddle_r[8:0];
        sh_bx <= reg_ball[25:16];
        sh_by <= reg_ball[8:0];
        sh_en <= reg_ctrl[0];
        sh_fg <= reg_ctrl[11:8];
        sh_bg <= reg_ctrl[15:12];
      end
    end
  end

  // 11-bit compares keep top+height from wrapping; off-screen parts are dropped by the visible test.
  always_comb begin
    x       = {1'b0, h_cnt};
    y       = {1'b0, v_cnt};
    visible = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    hit     = 1'b0;
    if ((x >= PL_X0) && (x < PL_X1) && (y >= {2'b0, sh_pl}) && (y < {2'b0, sh_pl} + PAD_H))
      hit = 1'b1;
    if ((x >= PR_X0) && (x < PR_X1) && (y >= {2'b0, sh_pr}) && (y < {2'b0, sh_pr} + PAD_H))
      hit = 1'b1;
    if ((x >= {1'b0, sh_bx}) && (x < {1'b0, sh_bx} + BALL) &&
        (y >= {2'b0, sh_by}) && (y < {2'b0, sh_by} + BALL))
      hit = 1'b1;
`ifdef RENDER_WALLS_EN
    if ((y < 11'd8) || ((y >= 11'(V_ACTIVE - 8)) && (y < 11'(V_ACTIVE))))
      hit = 1'b1;
`endif
    hsync_n = !((h_cnt >= 10'(H_ACTIVE + H_FP)) && (h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
    vsync_n = !((v_cnt >= 10'(V_ACTIVE + V_FP)) && (v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC)));
  end

  assign pix = (s1_visible && sh_en) ? (s1_hit ? sh_fg : sh_bg) : 4'h0;

  // Syncs ride the same two tick stages as colour so the outputs stay aligned.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      s1_visible <= 1'b0;
      s1_hit     <= 1'b0;
      s1_hsync   <= 1'b1;
      s1_vsync   <= 1'b1;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      vga_hsync  <= 1'b1;
      vga_vsync  <= 1'b1;
    end else if (tick) begin
      s1_visible <= visible;
      s1_hit     <= hit;
      s1_hsync   <= hsync_n;
      s1_vsync   <= vsync_n;
      vga_r      <= pix;
      vga_g      <= pix;
      vga_b      <= pix;
      vga_hsync  <= s1_hsync;
      vga_vsync  <= s1_vsync;
    end
  end

endmodule

// File: tb/tb_pong_sprite_renderer.sv
// tb_pong_sprite_renderer: scaled-down raster checked clock-by-clock against a frame-level reference model.
// Honours RENDER_WALLS_EN the same way the design does.
module tb_pong_sprite_renderer;

  localparam int CLK_DIV = 3;
  localparam int PW = 3;
  localparam int PH = 6;
  localparam int BS = 4;
  localparam int PLX = 2;
  localparam int PRX = 42;
  localparam int HA = 48;
  localparam int HFP = 4;
  localparam int HS = 8;
  localparam int HBP = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VA = 24;
  localparam int VFP = 2;
  localparam int VS = 2;
  localparam int VBP = 2;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME_CLKS = HT * VT * CLK_DIV;
  localparam int FIRST_HS_EDGE = (HA + HFP + 2) * CLK_DIV;
  localparam int NP = 6;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [31:0] reg_paddle_l = '0;
  logic [31:0] reg_paddle_r = '0;
  logic [31:0] reg_ball = '0;
  logic [31:0] reg_ctrl = '0;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic vga_hsync;
  logic vga_vsync;
  logic frame_start;

  int tests_run = 0;
  int tests_failed = 0;
  int n_edges = 0;
  int model_loads = 0;
  int dut_starts = 0;
  int lit_count = 0;
  logic [31:0] m_pl = '0;
  logic [31:0] m_pr = '0;
  logic [31:0] m_ball = '0;
  logic [31:0] m_ctrl = '0;
  int probe_x [NP] = '{2, 5, 2, 2, 47, 0};
  int probe_y [NP] = '{9, 9, 8, 15, 23, 22};
  logic [11:0] probe_val [NP];

  pong_sprite_renderer #(
    .CLK_DIV(CLK_DIV), .PADDLE_W(PW), .PADDLE_H(PH), .BALL_SZ(BS),
    .PADDLE_L_X(PLX), .PADDLE_R_X(PRX),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(rstn),
    .reg_paddle_l(reg_paddle_l),
    .reg_paddle_r(reg_paddle_r),
    .reg_ball(reg_ball),
    .reg_ctrl(reg_ctrl),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic in_rect(input int px, input int py, input int rx, input int ry,
                                   input int w, input int h);
    return (px >= rx) && (px < rx + w) && (py >= ry) && (py < ry + h);
  endfunction

  // Expected {rgb, hsync, vsync} after n clock edges out of reset: pixel index lags ticks by two.
  function automatic logic [13:0] model_out(input int n);
    int t;
    int q;
    int h;
    int v;
    logic hit;
    logic hs;
    logic vs;
    logic [3:0] c;
    t = n / CLK_DIV;
    if (t < 2) return {12'h000, 1'b1, 1'b1};
    q = t - 2;
    h = q % HT;
    v = (q / HT) % VT;
    hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
    c = 4'h0;
    if (h < HA && v < VA && m_ctrl[0]) begin
      hit = in_rect(h, v, PLX, int'(m_pl[8:0]), PW, PH) ||
            in_rect(h, v, PRX, int'(m_pr[8:0]), PW, PH) ||
            in_rect(h, v, int'(m_ball[25:16]), int'(m_ball[8:0]), BS, BS);
`ifdef RENDER_WALLS_EN
      if (v < 8 || v >= VA - 8) hit = 1'b1;
`endif
      c = hit ? m_ctrl[11:8] : m_ctrl[15:12];
    end
    return {c, c, c, hs, vs};
  endfunction

  task automatic checkOutput(input logic fs_exp);
    logic [14:0] expv;
    int t;
    int q;
    t = n_edges / CLK_DIV;
    if (frame_start === 1'b1) dut_starts++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) lit_count++;
    if (t >= 2 && rstn) begin
      q = t - 2;
      for (int i = 0; i < NP; i++)
        if ((q % HT) == probe_x[i] && ((q / HT) % VT) == probe_y[i])
          probe_val[i] = {vga_r, vga_g, vga_b};
    end
    if (tests_failed < 20) begin
      expv = {model_out(n_edges), fs_exp};
      tests_run++;
      assert ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_start} === expv) else begin
        tests_failed++;
        $error("[TB] FAIL outputs edge=%0d: observed rgb/hs/vs/fs=%h expected %h", n_edges,
               {vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_start}, expv);
      end
    end
  endtask

  // One clock: advance the model alongside the design, then sample 1 time unit after the edge.
  task automatic applyStimulus(input int cycles);
    logic loaded;
    repeat (cycles) begin
      @(posedge clk);
      loaded = 1'b0;
      if (!rstn) begin
        n_edges = 0;
        m_pl = '0;
        m_pr = '0;
        m_ball = '0;
        m_ctrl = '0;
      end else begin
        n_edges++;
        if ((n_edges % CLK_DIV) == 0 && ((n_edges / CLK_DIV - 1) % (HT * VT)) == VA * HT) begin
          m_pl = reg_paddle_l;
          m_pr = reg_paddle_r;
          m_ball = reg_ball;
          m_ctrl = reg_ctrl;
          loaded = 1'b1;
          model_loads++;
        end
      end
      #1;
      checkOutput(loaded);
    end
  endtask

  task automatic randomWrite();
    case ($urandom_range(0, 3))
      0: reg_paddle_l = {23'($urandom), 9'($urandom_range(0, VA + 4))};
      1: reg_paddle_r = {23'($urandom), 9'($urandom_range(0, VA + 4))};
      2: reg_ball = {6'($urandom), 10'($urandom_range(0, HA + 4)), 7'($urandom),
                     9'($urandom_range(0, VA + 4))};
      default: begin
        reg_ctrl = $urandom;
        reg_ctrl[0] = ($urandom_range(0, 3) != 0);
      end
    endcase
  endtask

  task automatic runFrame(input logic random_writes);
    for (int i = 0; i < FRAME_CLKS - 1; i++) begin
      applyStimulus(1);
      if (random_writes && $urandom_range(0, 199) == 0) randomWrite();
    end
  endtask

  task automatic clearProbes();
    for (int i = 0; i < NP; i++) probe_val[i] = 'x;
  endtask

  task automatic checkNamed(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkProbe(input int i, input logic [11:0] expected);
    tests_run++;
    assert (probe_val[i] === expected) else begin
      tests_failed++;
      $error("[TB] FAIL pixel(%0d,%0d): observed %h expected %h", probe_x[i], probe_y[i],
             probe_val[i], expected);
    end
  endtask

  task automatic checkFirstHsync(input string tag);
    int k = 0;
    while (vga_hsync === 1'b1 && k < 1000) begin
      applyStimulus(1);
      k++;
    end
    checkNamed(tag, n_edges, FIRST_HS_EDGE);
  endtask

  task automatic waitFrameStart();
    int k = 0;
    while (frame_start !== 1'b1 && k < 2 * FRAME_CLKS) begin
      applyStimulus(1);
      k++;
    end
    checkNamed("frame_start_seen", int'(frame_start === 1'b1), 1);
  endtask

  task automatic loadNext();
    applyStimulus(1);
    checkNamed("frame_start_pulse", int'(frame_start === 1'b1), 1);
  endtask

  initial begin
    applyStimulus(10);
    rstn = 1'b1;
    checkFirstHsync("first_hsync_edge");

    // Left paddle at row 9, fg white on black.
    reg_ctrl = 32'h0000_0F01;
    reg_paddle_l = 32'd9;
    reg_paddle_r = 32'd0;
    reg_ball = {16'd20, 16'd12};
    waitFrameStart();
    clearProbes();
    runFrame(1'b0);
    checkProbe(0, 12'hFFF);
    checkProbe(1, 12'h000);
    checkProbe(2, 12'h000);
    checkProbe(3, 12'h000);

    // Ball in the bottom-right corner must clip, not wrap to x = 0.
    reg_ball = {16'(HA - 2), 16'(VA - 2)};
    loadNext();
    clearProbes();
    runFrame(1'b0);
    checkProbe(4, 12'hFFF);
`ifdef RENDER_WALLS_EN
    checkProbe(5, 12'hFFF);
`else
    checkProbe(5, 12'h000);
`endif

    // Mid-frame paddle_r write is held off until the next shadow load.
    reg_ctrl = 32'h0000_3A01;
    loadNext();
    applyStimulus(HT * 10 * CLK_DIV);
    reg_paddle_r = 32'd15;
    for (int i = 0; i < FRAME_CLKS - 1 - HT * 10 * CLK_DIV; i++) applyStimulus(1);

    // Display disabled: black everywhere, syncs still running.
    reg_ctrl = 32'h0000_5A00;
    loadNext();
    lit_count = 0;
    runFrame(1'b0);
    checkNamed("disabled_lit_pixels", lit_count, 0);

    reg_ctrl = 32'h0000_0C01;
    loadNext();
    runFrame(1'b1);
    loadNext();
    runFrame(1'b1);

    // Mid-frame reset restarts the raster at (0,0) with cleared shadows.
    applyStimulus(HT * 5 * CLK_DIV + 7);
    rstn = 1'b0;
    applyStimulus(5);
    rstn = 1'b1;
    checkFirstHsync("hsync_after_midframe_reset");
    waitFrameStart();
    applyStimulus(HT * 3 * CLK_DIV);

    checkNamed("frame_start_count", dut_starts, model_loads);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
